// File: rtl/sipo_deser.sv
// MSB-first serial-to-parallel deserializer, one-entry output register, valid/ready handshake.
// dout_valid rises on the edge that samples bit N; a word completing while dout is held sets sticky overrun.
module sipo_deser #(
  parameter  int N  = 4,
  localparam int CW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          sin,
  input  logic          sin_valid,
  output logic [N-1:0]  dout,
  output logic          dout_valid,
  input  logic          dout_ready,
  output logic [CW-1:0] bit_cnt,
  output logic          overrun
);

  typedef enum logic {S_EMPTY, S_FULL} state_t;

  localparam logic [CW-1:0] LAST_BIT = CW'(N - 1);

  state_t        state_q, state_d;
  logic [N-1:0]  sh_q, sh_d;
  logic [N-1:0]  dout_q, dout_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovr_q, ovr_d;

  logic [N-1:0]  word;
  logic          frame_done;

  assign word       = {sh_q[N-2:0], sin};
  assign frame_done = sin_valid && (cnt_q == LAST_BIT);

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    dout_d  = dout_q;
    cnt_d   = cnt_q;
    ovr_d   = ovr_q;
    if (clr) begin
      state_d = S_EMPTY;
      sh_d    = '0;
      dout_d  = '0;
      cnt_d   = '0;
      ovr_d   = 1'b0;
    end else begin
      if (sin_valid) begin
        sh_d  = word;
        cnt_d = frame_done ? '0 : cnt_q + 1'b1;
      end
      case (state_q)
        S_EMPTY: begin
          if (frame_done) begin
            dout_d  = word;
            state_d = S_FULL;
          end
        end
        S_FULL: begin
          // A consumer accepting on the completing cycle frees the slot for the new word.
          if (frame_done) begin
            if (dout_ready) dout_d = word;
            else            ovr_d  = 1'b1;
          end else if (dout_ready) begin
            state_d = S_EMPTY;
          end
        end
        default: state_d = S_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_EMPTY;
      sh_q    <= '0;
      dout_q  <= '0;
      cnt_q   <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      dout_q  <= dout_d;
      cnt_q   <= cnt_d;
      ovr_q   <= ovr_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = (state_q == S_FULL);
  assign bit_cnt    = cnt_q;
  assign overrun    = ovr_q;

endmodule
